// File: rtl/mem_arbiter_pkg.sv
// Shared types for the unified-memory arbiter.
// Imported as mem_arb_pkg by the arbiter, its interface and bench.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_IBUSY,
    ARB_DBUSY
  } arb_state_t;

  typedef enum logic {
    PORT_I,
    PORT_D
  } arb_port_t;

  localparam logic [31:0] ARB_RDATA_ABORT = 32'h0;

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch, load/store and memory bus bundle for mem_arbiter.
// MEM_ARB_PERF_EN adds the performance counter outputs.
interface mem_arbiter_if;

  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_done;
  logic [31:0] i_rdata;

  logic        d_req;
  logic        d_we;
  logic [3:0]  d_wmask;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_done;
  logic [31:0] d_rdata;

  logic        m_req;
  logic        m_we;
  logic [3:0]  m_wmask;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_ready;
  logic [31:0] m_rdata;

  logic        stall;
  logic        err;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_istall;
  logic [31:0] perf_dstall;
  logic [31:0] perf_conflict;
`endif

  modport slave (
    input  i_req, i_addr,
    input  d_req, d_we, d_wmask,
    input  d_addr, d_wdata,
    input  m_ready, m_rdata,
    output i_gnt, i_done, i_rdata,
    output d_gnt, d_done, d_rdata,
    output m_req, m_we, m_wmask,
    output m_addr, m_wdata,
`ifdef MEM_ARB_PERF_EN
    output perf_istall,
    output perf_dstall,
    output perf_conflict,
`endif
    output stall, err
  );

  modport master (
    output i_req, i_addr,
    output d_req, d_we, d_wmask,
    output d_addr, d_wdata,
    output m_ready, m_rdata,
    input  i_gnt, i_done, i_rdata,
    input  d_gnt, d_done, d_rdata,
    input  m_req, m_we, m_wmask,
    input  m_addr, m_wdata,
`ifdef MEM_ARB_PERF_EN
    input  perf_istall,
    input  perf_dstall,
    input  perf_conflict,
`endif
    input  stall, err
  );

endinterface

// File: rtl/mem_arbiter_sat_counter.sv
// Saturating event counter with synchronous clear.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + WIDTH'(1);
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one variable-latency memory port between fetch and load/store.
// MEM_ARB_PERF_EN adds saturating stall/conflict counters.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_V = CW'(TIMEOUT);

  arb_state_t    state;
  arb_port_t     last;
  arb_port_t     pick;
  logic          any;
  logic [CW-1:0] cnt;
  logic          i_v;
  logic          d_v;

  // a port that just completed may not re-win in its done cycle
  assign i_v = bus.i_req & ~bus.i_done;
  assign d_v = bus.d_req & ~bus.d_done;

  assign bus.stall = i_v | d_v;

  always_comb begin
    any  = 1'b0;
    pick = PORT_I;
    unique case (1'b1)
      i_v && d_v: begin
        any  = 1'b1;
        pick = (last == PORT_I) ? PORT_D : PORT_I;
      end
      d_v && !i_v: begin
        any  = 1'b1;
        pick = PORT_D;
      end
      i_v && !d_v: begin
        any  = 1'b1;
        pick = PORT_I;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ARB_IDLE;
      last        <= PORT_I;
      cnt         <= '0;
      bus.m_req   <= 1'b0;
      bus.m_we    <= 1'b0;
      bus.m_wmask <= 4'h0;
      bus.m_addr  <= 32'h0;
      bus.m_wdata <= 32'h0;
      bus.i_gnt   <= 1'b0;
      bus.d_gnt   <= 1'b0;
      bus.i_done  <= 1'b0;
      bus.d_done  <= 1'b0;
      bus.err     <= 1'b0;
      bus.i_rdata <= 32'h0;
      bus.d_rdata <= 32'h0;
    end else begin
      bus.i_gnt  <= 1'b0;
      bus.d_gnt  <= 1'b0;
      bus.i_done <= 1'b0;
      bus.d_done <= 1'b0;
      bus.err    <= 1'b0;
      unique case (state)
        ARB_IDLE: begin
          if (any) begin
            bus.m_req <= 1'b1;
            cnt       <= '0;
            last      <= pick;
            if (pick == PORT_D) begin
              bus.m_we    <= bus.d_we;
              bus.m_wmask <= bus.d_wmask;
              bus.m_addr  <= bus.d_addr;
              bus.m_wdata <= bus.d_wdata;
              bus.d_gnt   <= 1'b1;
              state       <= ARB_DBUSY;
            end else begin
              bus.m_we    <= 1'b0;
              bus.m_wmask <= 4'h0;
              bus.m_addr  <= bus.i_addr;
              bus.m_wdata <= 32'h0;
              bus.i_gnt   <= 1'b1;
              state       <= ARB_IBUSY;
            end
          end
        end
        ARB_IBUSY, ARB_DBUSY: begin
          // m_ready wins over a timeout landing on the same cycle
          if (bus.m_ready || (cnt == TO_V)) begin
            bus.m_req <= 1'b0;
            bus.err   <= ~bus.m_ready;
            state     <= ARB_IDLE;
            if (state == ARB_IBUSY) begin
              bus.i_done  <= 1'b1;
              bus.i_rdata <= bus.m_ready ?
                bus.m_rdata : ARB_RDATA_ABORT;
            end else begin
              bus.d_done <= 1'b1;
              if (!bus.m_ready)
                bus.d_rdata <= ARB_RDATA_ABORT;
              else if (!bus.m_we)
                bus.d_rdata <= bus.m_rdata;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_PERF_EN
  sat_counter #(.WIDTH(32)) u_istall (
    .clk   (clk),
    .clr   (reset),
    .inc   (i_v),
    .count (bus.perf_istall)
  );

  sat_counter #(.WIDTH(32)) u_dstall (
    .clk   (clk),
    .clr   (reset),
    .inc   (d_v),
    .count (bus.perf_dstall)
  );

  sat_counter #(.WIDTH(32)) u_conflict (
    .clk   (clk),
    .clr   (reset),
    .inc   ((state == ARB_IDLE) && i_v && d_v),
    .count (bus.perf_conflict)
  );
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (TIMEOUT = 4).
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   asserts = 0;
  int   fails = 0;

  mem_arbiter_if bus();

  mem_arbiter #(.TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_req   = 1'b0;
    bus.i_addr  = 32'h0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_wmask = 4'h0;
    bus.d_addr  = 32'h0;
    bus.d_wdata = 32'h0;
    bus.m_ready = 1'b0;
    bus.m_rdata = 32'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    asserts++;
    if ({bus.m_req, bus.m_we, bus.m_wmask} !== 6'h0) begin
      fails++;
      $display("FAIL rst_mctl: got %b want 0",
        {bus.m_req, bus.m_we, bus.m_wmask});
    end
    asserts++;
    if ({bus.m_addr, bus.m_wdata} !== 64'h0) begin
      fails++;
      $display("FAIL rst_mbus: got %h want 0",
        {bus.m_addr, bus.m_wdata});
    end
    asserts++;
    if ({bus.i_gnt, bus.d_gnt, bus.i_done, bus.d_done, bus.err}
        !== 5'h0) begin
      fails++;
      $display("FAIL rst_pulses: got %b want 0",
        {bus.i_gnt, bus.d_gnt, bus.i_done, bus.d_done, bus.err});
    end
    asserts++;
    if ({bus.i_rdata, bus.d_rdata} !== 64'h0) begin
      fails++;
      $display("FAIL rst_rdata: got %h want 0",
        {bus.i_rdata, bus.d_rdata});
    end
    reset = 1'b0;
    step();
    asserts++;
    if (bus.stall !== 1'b0) begin
      fails++;
      $display("FAIL rst_stall: got %b want 0", bus.stall);
    end
  endtask

  task automatic test_single_fetch();
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h40;
    #1;
    asserts++;
    if (bus.stall !== 1'b1) begin
      fails++;
      $display("FAIL f_stall0: got %b want 1", bus.stall);
    end
    step();
    asserts++;
    if ({bus.i_gnt, bus.m_req, bus.m_we, bus.stall} !== 4'b1101) begin
      fails++;
      $display("FAIL f_gnt: got %b want 1101",
        {bus.i_gnt, bus.m_req, bus.m_we, bus.stall});
    end
    asserts++;
    if (bus.m_addr !== 32'h40) begin
      fails++;
      $display("FAIL f_maddr: got %h want 40", bus.m_addr);
    end
    step();
    asserts++;
    if ({bus.i_gnt, bus.stall} !== 2'b01) begin
      fails++;
      $display("FAIL f_c2: got %b want 01", {bus.i_gnt, bus.stall});
    end
    step();
    bus.m_ready = 1'b1;
    bus.m_rdata = 32'h0050_0093;
    #1;
    asserts++;
    if ({bus.i_done, bus.stall} !== 2'b01) begin
      fails++;
      $display("FAIL f_c3: got %b want 01", {bus.i_done, bus.stall});
    end
    step();
    bus.m_ready = 1'b0;
    bus.m_rdata = 32'h0;
    #1;
    asserts++;
    if ({bus.i_done, bus.m_req, bus.stall, bus.err} !== 4'b1000) begin
      fails++;
      $display("FAIL f_done: got %b want 1000",
        {bus.i_done, bus.m_req, bus.stall, bus.err});
    end
    asserts++;
    if (bus.i_rdata !== 32'h0050_0093) begin
      fails++;
      $display("FAIL f_rdata: got %h want 00500093", bus.i_rdata);
    end
    step();
    asserts++;
    if ({bus.i_gnt, bus.i_done} !== 2'b00) begin
      fails++;
      $display("FAIL f_mask: got %b want 00", {bus.i_gnt, bus.i_done});
    end
    bus.i_req = 1'b0;
    step();
  endtask

  task automatic test_load();
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_wmask = 4'hF;
    bus.d_addr  = 32'h200;
    step();
    asserts++;
    if ({bus.d_gnt, bus.m_we} !== 2'b10 || bus.m_addr !== 32'h200)
    begin
      fails++;
      $display("FAIL ld_gnt: got %b/%h want 10/200",
        {bus.d_gnt, bus.m_we}, bus.m_addr);
    end
    bus.m_ready = 1'b1;
    bus.m_rdata = 32'h1234_5678;
    step();
    bus.m_ready = 1'b0;
    bus.d_req   = 1'b0;
    asserts++;
    if (bus.d_done !== 1'b1 || bus.d_rdata !== 32'h1234_5678) begin
      fails++;
      $display("FAIL ld_done: got %b/%h want 1/12345678",
        bus.d_done, bus.d_rdata);
    end
    asserts++;
    if (bus.i_rdata !== 32'h0050_0093) begin
      fails++;
      $display("FAIL ld_irdata: got %h want 00500093", bus.i_rdata);
    end
    step();
  endtask

  task automatic test_store();
    logic [69:0] exp;
    exp = {1'b1, 1'b1, 4'h3, 32'h100, 32'hDEAD_BEEF};
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_wmask = 4'h3;
    bus.d_addr  = 32'h100;
    bus.d_wdata = 32'hDEAD_BEEF;
    step();
    asserts++;
    if (bus.d_gnt !== 1'b1) begin
      fails++;
      $display("FAIL st_gnt: got %b want 1", bus.d_gnt);
    end
    bus.d_addr  = 32'h0;
    bus.d_wdata = 32'h0;
    bus.d_wmask = 4'h0;
    for (int k = 0; k < 3; k++) begin
      asserts++;
      if ({bus.m_req, bus.m_we, bus.m_wmask, bus.m_addr, bus.m_wdata}
          !== exp) begin
        fails++;
        $display("FAIL st_cmd%0d: got %h want %h", k,
          {bus.m_req, bus.m_we, bus.m_wmask, bus.m_addr, bus.m_wdata},
          exp);
      end
      if (k == 2) begin
        bus.m_ready = 1'b1;
        bus.m_rdata = 32'hFFFF_FFFF;
      end
      step();
    end
    bus.m_ready = 1'b0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    asserts++;
    if ({bus.d_done, bus.err, bus.m_req} !== 3'b100) begin
      fails++;
      $display("FAIL st_done: got %b want 100",
        {bus.d_done, bus.err, bus.m_req});
    end
    asserts++;
    if (bus.d_rdata !== 32'h1234_5678) begin
      fails++;
      $display("FAIL st_rdata: got %h want 12345678", bus.d_rdata);
    end
    step();
  endtask

  task automatic test_back_to_back();
    arb_port_t got [4];
    arb_port_t exp [4];
    int n;
    exp = '{PORT_D, PORT_I, PORT_D, PORT_I};
    n = 0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h40;
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h80;
    for (int c = 0; c < 40 && n < 4; c++) begin
      step();
      if (bus.d_gnt === 1'b1) begin
        got[n] = PORT_D;
        n++;
      end else if (bus.i_gnt === 1'b1) begin
        got[n] = PORT_I;
        n++;
      end
      bus.m_ready = bus.m_req;
      bus.m_rdata = 32'hA5A5_0000 + 32'(c);
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    step();
    bus.m_ready = 1'b0;
    step();
    asserts++;
    if (n !== 4) begin
      fails++;
      $display("FAIL b2b_count: got %0d want 4", n);
    end
    for (int k = 0; k < 4; k++) begin
      if (k < n) begin
        asserts++;
        if (got[k] !== exp[k]) begin
          fails++;
          $display("FAIL b2b_order%0d: got %s want %s", k,
            got[k].name(), exp[k].name());
        end
      end
    end
  endtask

  task automatic test_tie();
    bus.i_req   = 1'b1;
    bus.d_req   = 1'b1;
    bus.m_rdata = 32'h1111_2222;
    step();
    asserts++;
    if ({bus.d_gnt, bus.i_gnt} !== 2'b10) begin
      fails++;
      $display("FAIL tie_d: got %b want 10", {bus.d_gnt, bus.i_gnt});
    end
    bus.m_ready = 1'b1;
    step();
    bus.i_req   = 1'b0;
    bus.d_req   = 1'b0;
    bus.m_ready = 1'b0;
    step();
    bus.i_req = 1'b1;
    bus.d_req = 1'b1;
    step();
    asserts++;
    if ({bus.d_gnt, bus.i_gnt} !== 2'b01) begin
      fails++;
      $display("FAIL tie_i: got %b want 01", {bus.d_gnt, bus.i_gnt});
    end
    bus.m_ready = 1'b1;
    step();
    bus.i_req   = 1'b0;
    bus.d_req   = 1'b0;
    bus.m_ready = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h300;
    step();
    asserts++;
    if (bus.d_gnt !== 1'b1) begin
      fails++;
      $display("FAIL to_gnt: got %b want 1", bus.d_gnt);
    end
    asserts++;
    if (bus.d_rdata !== 32'h1111_2222) begin
      fails++;
      $display("FAIL to_pre: got %h want 11112222", bus.d_rdata);
    end
    for (int k = 2; k <= 5; k++) begin
      step();
      asserts++;
      if ({bus.err, bus.d_done, bus.m_req} !== 3'b001) begin
        fails++;
        $display("FAIL to_wait%0d: got %b want 001", k,
          {bus.err, bus.d_done, bus.m_req});
      end
    end
    step();
    bus.d_req = 1'b0;
    asserts++;
    if ({bus.err, bus.d_done, bus.m_req} !== 3'b110) begin
      fails++;
      $display("FAIL to_abort: got %b want 110",
        {bus.err, bus.d_done, bus.m_req});
    end
    asserts++;
    if (bus.d_rdata !== 32'h0) begin
      fails++;
      $display("FAIL to_rdata: got %h want 0", bus.d_rdata);
    end
    step();
    asserts++;
    if ({bus.err, bus.d_done} !== 2'b00) begin
      fails++;
      $display("FAIL to_after: got %b want 00", {bus.err, bus.d_done});
    end
  endtask

  task automatic test_timeout_edge();
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h304;
    step();
    asserts++;
    if (bus.d_gnt !== 1'b1) begin
      fails++;
      $display("FAIL te_gnt: got %b want 1", bus.d_gnt);
    end
    for (int k = 2; k <= 5; k++) begin
      step();
      asserts++;
      if ({bus.err, bus.d_done} !== 2'b00) begin
        fails++;
        $display("FAIL te_wait%0d: got %b want 00", k,
          {bus.err, bus.d_done});
      end
    end
    bus.m_ready = 1'b1;
    bus.m_rdata = 32'hCAFE_F00D;
    step();
    bus.m_ready = 1'b0;
    bus.d_req   = 1'b0;
    asserts++;
    if ({bus.err, bus.d_done, bus.m_req} !== 3'b010) begin
      fails++;
      $display("FAIL te_done: got %b want 010",
        {bus.err, bus.d_done, bus.m_req});
    end
    asserts++;
    if (bus.d_rdata !== 32'hCAFE_F00D) begin
      fails++;
      $display("FAIL te_rdata: got %h want cafef00d", bus.d_rdata);
    end
    step();
  endtask

  task automatic test_reset_busy();
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h44;
    step();
    asserts++;
    if ({bus.i_gnt, bus.m_req} !== 2'b11) begin
      fails++;
      $display("FAIL rb_gnt: got %b want 11", {bus.i_gnt, bus.m_req});
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.i_req = 1'b0;
    asserts++;
    if ({bus.m_req, bus.i_done, bus.err, bus.i_gnt} !== 4'h0) begin
      fails++;
      $display("FAIL rb_ctl: got %b want 0000",
        {bus.m_req, bus.i_done, bus.err, bus.i_gnt});
    end
    asserts++;
    if ({bus.m_addr, bus.i_rdata, bus.d_rdata} !== 96'h0) begin
      fails++;
      $display("FAIL rb_data: got %h want 0",
        {bus.m_addr, bus.i_rdata, bus.d_rdata});
    end
    bus.m_ready = 1'b1;
    step();
    bus.m_ready = 1'b0;
    asserts++;
    if ({bus.i_done, bus.err, bus.m_req} !== 3'b000) begin
      fails++;
      $display("FAIL rb_lost: got %b want 000",
        {bus.i_done, bus.err, bus.m_req});
    end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_fetch();
    test_load();
    test_store();
    test_back_to_back();
    test_tie();
    test_timeout();
    test_timeout_edge();
    test_reset_busy();
    $display("End of test - %0d assertions evaluated, %0d failures",
      asserts, fails);
    $finish;
  end

endmodule
